// File: rtl/toy_bus_dmem_req_buf.sv
// DMEM request FIFO with outstanding-request limiter; 1-cycle request latency (0 with TOY_BUS_DMEM_REQ_BUF_BYPASS_EN), 0-cycle ack path.
// Backpressure: in_req_rdy drops when the FIFO is full; out_req_vld is held low while MAX_OUTSTD requests await acks.
module toy_bus_dmem_req_buf #(
    parameter int DEPTH      = 2,
    parameter int MAX_OUTSTD = 4
) (
    input  logic                       clk,
    input  logic                       rst,

    input  logic                       in_req_vld,
    output logic                       in_req_rdy,
    input  logic [31:0]                in_req_addr,
    input  logic [3:0]                 in_req_strb,
    input  logic [31:0]                in_req_data,
    input  logic                       in_req_opcode,
    input  logic [3:0]                 in_req_src_id,
    input  logic [3:0]                 in_req_tgt_id,

    output logic                       out_req_vld,
    input  logic                       out_req_rdy,
    output logic [31:0]                out_req_addr,
    output logic [3:0]                 out_req_strb,
    output logic [31:0]                out_req_data,
    output logic                       out_req_opcode,
    output logic [3:0]                 out_req_src_id,
    output logic [3:0]                 out_req_tgt_id,

    input  logic                       out_ack_vld,
    output logic                       out_ack_rdy,
    input  logic                       out_ack_opcode,
    input  logic [31:0]                out_ack_data,
    input  logic [3:0]                 out_ack_src_id,
    input  logic [3:0]                 out_ack_tgt_id,

    output logic                       in_ack_vld,
    input  logic                       in_ack_rdy,
    output logic                       in_ack_opcode,
    output logic [31:0]                in_ack_data,
    output logic [3:0]                 in_ack_src_id,
    output logic [3:0]                 in_ack_tgt_id,

    output logic [3:0]                 outstd_cnt,
    output logic [$clog2(DEPTH):0]     fifo_cnt,
    output logic                       err_underflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef struct packed {
        logic [31:0] addr;
        logic [3:0]  strb;
        logic [31:0] data;
        logic        opcode;
        logic [3:0]  src_id;
        logic [3:0]  tgt_id;
    } req_t;

    req_t          mem [DEPTH];
    req_t          in_pl;
    req_t          head_pl;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          issue_ok;
    logic          fifo_vld;
    logic          byp;
    logic          push;
    logic          pop;
    logic          issue;
    logic          ack_done;

    assign in_pl = '{addr: in_req_addr, strb: in_req_strb, data: in_req_data,
                     opcode: in_req_opcode, src_id: in_req_src_id, tgt_id: in_req_tgt_id};

    assign issue_ok   = (outstd_cnt < 4'(MAX_OUTSTD));
    assign in_req_rdy = (fifo_cnt != CW'(DEPTH));
    assign fifo_vld   = (fifo_cnt != '0) && issue_ok;

`ifdef TOY_BUS_DMEM_REQ_BUF_BYPASS_EN
    // Empty FIFO with a ready sink: forward the master's beat without storing it.
    assign byp     = (fifo_cnt == '0) && issue_ok && in_req_vld && out_req_rdy;
    assign head_pl = byp ? in_pl : mem[rd_ptr];
`else
    assign byp     = 1'b0;
    assign head_pl = mem[rd_ptr];
`endif

    assign out_req_vld    = fifo_vld || byp;
    assign out_req_addr   = head_pl.addr;
    assign out_req_strb   = head_pl.strb;
    assign out_req_data   = head_pl.data;
    assign out_req_opcode = head_pl.opcode;
    assign out_req_src_id = head_pl.src_id;
    assign out_req_tgt_id = head_pl.tgt_id;

    assign push     = in_req_vld && in_req_rdy && !byp;
    assign pop      = fifo_vld && out_req_rdy;
    assign issue    = out_req_vld && out_req_rdy;
    assign ack_done = out_ack_vld && in_ack_rdy;

    assign in_ack_vld    = out_ack_vld;
    assign out_ack_rdy   = in_ack_rdy;
    assign in_ack_opcode = out_ack_opcode;
    assign in_ack_data   = out_ack_data;
    assign in_ack_src_id = out_ack_src_id;
    assign in_ack_tgt_id = out_ack_tgt_id;

    always_ff @(posedge clk) begin
        if (push && !rst) begin
            mem[wr_ptr] <= in_pl;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            fifo_cnt      <= '0;
            outstd_cnt    <= '0;
            err_underflow <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + CW'(1);
                2'b01:   fifo_cnt <= fifo_cnt - CW'(1);
                default: fifo_cnt <= fifo_cnt;
            endcase
            // A stray ack at zero is forwarded but must not wrap the counter.
            if (issue && !ack_done) begin
                outstd_cnt <= outstd_cnt + 4'd1;
            end else if (ack_done && !issue && outstd_cnt != 4'd0) begin
                outstd_cnt <= outstd_cnt - 4'd1;
            end
            if (ack_done && outstd_cnt == 4'd0) begin
                err_underflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_toy_bus_dmem_req_buf.sv
// Bench for toy_bus_dmem_req_buf: queue-based reference model checked every cycle plus directed literal checks.
module tb_toy_bus_dmem_req_buf;

    localparam int DEPTH      = 2;
    localparam int MAX_OUTSTD = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_req_vld, in_req_rdy;
    logic [31:0] in_req_addr, in_req_data;
    logic [3:0]  in_req_strb, in_req_src_id, in_req_tgt_id;
    logic        in_req_opcode;
    logic        out_req_vld, out_req_rdy;
    logic [31:0] out_req_addr, out_req_data;
    logic [3:0]  out_req_strb, out_req_src_id, out_req_tgt_id;
    logic        out_req_opcode;
    logic        out_ack_vld, out_ack_rdy, out_ack_opcode;
    logic [31:0] out_ack_data;
    logic [3:0]  out_ack_src_id, out_ack_tgt_id;
    logic        in_ack_vld, in_ack_rdy, in_ack_opcode;
    logic [31:0] in_ack_data;
    logic [3:0]  in_ack_src_id, in_ack_tgt_id;
    logic [3:0]  outstd_cnt;
    logic [$clog2(DEPTH):0] fifo_cnt;
    logic        err_underflow;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    toy_bus_dmem_req_buf #(.DEPTH(DEPTH), .MAX_OUTSTD(MAX_OUTSTD)) dut (
        .clk(clk), .rst(rst),
        .in_req_vld(in_req_vld), .in_req_rdy(in_req_rdy),
        .in_req_addr(in_req_addr), .in_req_strb(in_req_strb), .in_req_data(in_req_data),
        .in_req_opcode(in_req_opcode), .in_req_src_id(in_req_src_id), .in_req_tgt_id(in_req_tgt_id),
        .out_req_vld(out_req_vld), .out_req_rdy(out_req_rdy),
        .out_req_addr(out_req_addr), .out_req_strb(out_req_strb), .out_req_data(out_req_data),
        .out_req_opcode(out_req_opcode), .out_req_src_id(out_req_src_id), .out_req_tgt_id(out_req_tgt_id),
        .out_ack_vld(out_ack_vld), .out_ack_rdy(out_ack_rdy),
        .out_ack_opcode(out_ack_opcode), .out_ack_data(out_ack_data),
        .out_ack_src_id(out_ack_src_id), .out_ack_tgt_id(out_ack_tgt_id),
        .in_ack_vld(in_ack_vld), .in_ack_rdy(in_ack_rdy),
        .in_ack_opcode(in_ack_opcode), .in_ack_data(in_ack_data),
        .in_ack_src_id(in_ack_src_id), .in_ack_tgt_id(in_ack_tgt_id),
        .outstd_cnt(outstd_cnt), .fifo_cnt(fifo_cnt), .err_underflow(err_underflow)
    );

    task automatic check(input string name, input logic [76:0] act, input logic [76:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: the FIFO is a queue of beats, outstanding is a plain integer.
    logic [76:0] mq[$];
    int          mo;
    bit          merr;
    logic [76:0] in_pl, out_pl;

    assign in_pl  = {in_req_addr, in_req_strb, in_req_data, in_req_opcode, in_req_src_id, in_req_tgt_id};
    assign out_pl = {out_req_addr, out_req_strb, out_req_data, out_req_opcode, out_req_src_id, out_req_tgt_id};

    function bit m_byp();
`ifdef TOY_BUS_DMEM_REQ_BUF_BYPASS_EN
        return (mq.size() == 0) && (mo < MAX_OUTSTD) && in_req_vld && out_req_rdy;
`else
        return 1'b0;
`endif
    endfunction

    function bit m_vld();
        return ((mq.size() != 0) && (mo < MAX_OUTSTD)) || m_byp();
    endfunction

    always @(posedge clk) begin
        bit byp, issue, push, ack;
        if (rst) begin
            mq.delete();
            mo   = 0;
            merr = 1'b0;
        end else begin
            byp   = m_byp();
            issue = m_vld() && out_req_rdy;
            push  = in_req_vld && (mq.size() < DEPTH) && !byp;
            ack   = out_ack_vld && in_ack_rdy;
            if (ack && mo == 0) merr = 1'b1;
            if (issue && !byp) void'(mq.pop_front());
            if (push) mq.push_back(in_pl);
            if (issue && !ack) mo++;
            else if (ack && !issue && mo > 0) mo--;
        end
    end

    always @(negedge clk) begin
        #1;
        if (!rst) begin
            check("in_req_rdy", 77'(in_req_rdy), 77'(mq.size() < DEPTH));
            check("out_req_vld", 77'(out_req_vld), 77'(m_vld()));
            if (m_vld()) check("out_req_payload", out_pl, m_byp() ? in_pl : mq[0]);
            check("fifo_cnt", 77'(fifo_cnt), 77'(mq.size()));
            check("outstd_cnt", 77'(outstd_cnt), 77'(mo));
            check("err_underflow", 77'(err_underflow), 77'(merr));
            check("ack_pass", {in_ack_vld, out_ack_rdy, in_ack_opcode, in_ack_data, in_ack_src_id, in_ack_tgt_id},
                  {out_ack_vld, in_ack_rdy, out_ack_opcode, out_ack_data, out_ack_src_id, out_ack_tgt_id});
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    function automatic logic [31:0] addr_of(input int i);
        return 32'h0000_0100 + 32'(i * 4);
    endfunction

    task automatic set_req(input int i);
        in_req_vld    = 1'b1;
        in_req_addr   = addr_of(i);
        in_req_data   = 32'hA000_0000 + 32'(i);
        in_req_strb   = 4'(i + 1);
        in_req_opcode = i[0];
        in_req_src_id = 4'(i);
        in_req_tgt_id = 4'(15 - i);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, errors=%0d", errors);
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        in_req_vld = 0; in_req_addr = 0; in_req_data = 0; in_req_strb = 0;
        in_req_opcode = 0; in_req_src_id = 0; in_req_tgt_id = 0;
        out_req_rdy = 1'b1;
        out_ack_vld = 0; out_ack_opcode = 0; out_ack_data = 0; out_ack_src_id = 0; out_ack_tgt_id = 0;
        in_ack_rdy = 1'b1;
        repeat (2) @(posedge clk);

        // Single write and its ack
        tick; rst = 1'b0;
        in_req_vld = 1'b1; in_req_addr = 32'h0000_1000; in_req_data = 32'hDEAD_BEEF;
        in_req_strb = 4'hF; in_req_opcode = 1'b1; in_req_src_id = 4'd1; in_req_tgt_id = 4'd2;
        #2 check("lit_reset_fifo_cnt", 77'(fifo_cnt), 77'd0);
        check("lit_reset_in_rdy", 77'(in_req_rdy), 77'd1);
        check("lit_t1_no_vld_yet", 77'(out_req_vld), 77'd0);
        tick; in_req_vld = 1'b0;
        #2 check("lit_t1_vld", 77'(out_req_vld), 77'd1);
        check("lit_t1_addr", 77'(out_req_addr), 77'h0000_1000);
        check("lit_t1_data", 77'(out_req_data), 77'hDEAD_BEEF);
        check("lit_t1_strb", 77'(out_req_strb), 77'hF);
        tick; out_ack_vld = 1'b1; out_ack_data = 32'h0BAD_F00D; out_ack_src_id = 4'd2; out_ack_tgt_id = 4'd1;
        #2 check("lit_t1_outstd1", 77'(outstd_cnt), 77'd1);
        check("lit_t1_ack_vld", 77'(in_ack_vld), 77'd1);
        check("lit_t1_ack_data", 77'(in_ack_data), 77'h0BAD_F00D);
        tick; out_ack_vld = 1'b0;
        #2 check("lit_t1_outstd0", 77'(outstd_cnt), 77'd0);

        // Outstanding limit: six back-to-back requests, no acks
        for (int i = 0; i < 6; i++) begin
            tick; set_req(i);
        end
        tick; in_req_vld = 1'b0;
        #2 check("lit_lim_outstd", 77'(outstd_cnt), 77'd4);
        check("lit_lim_fifo", 77'(fifo_cnt), 77'd2);
        check("lit_lim_in_rdy", 77'(in_req_rdy), 77'd0);
        check("lit_lim_vld", 77'(out_req_vld), 77'd0);
        tick; out_ack_vld = 1'b1;
        #2 check("lit_lim_vld_during_ack", 77'(out_req_vld), 77'd0);
        tick; out_ack_vld = 1'b0;
        #2 check("lit_lim_vld_after_ack", 77'(out_req_vld), 77'd1);
        check("lit_lim_5th_addr", 77'(out_req_addr), 77'(addr_of(4)));
        tick;
        #2 check("lit_lim_outstd_again", 77'(outstd_cnt), 77'd4);
        tick; out_ack_vld = 1'b1; in_ack_rdy = 1'b0;
        #2 check("lit_ack_rdy_low", 77'(out_ack_rdy), 77'd0);
        tick; in_ack_rdy = 1'b1;
        #2 check("lit_no_ack_done", 77'(outstd_cnt), 77'd4);
        repeat (4) tick;
        tick; out_ack_vld = 1'b0;
        #2 check("lit_drain_outstd", 77'(outstd_cnt), 77'd0);
        check("lit_drain_fifo", 77'(fifo_cnt), 77'd0);
        check("lit_drain_err", 77'(err_underflow), 77'd0);

        // Simultaneous pop and ack at outstd_cnt=2
        tick; set_req(8);
        tick; set_req(9);
        tick; set_req(10);
        tick; in_req_vld = 1'b0; out_ack_vld = 1'b1;
        #2 check("lit_sim_pre", 77'(outstd_cnt), 77'd2);
        check("lit_sim_vld", 77'(out_req_vld), 77'd1);
        tick;
        #2 check("lit_sim_post", 77'(outstd_cnt), 77'd2);
        check("lit_sim_fifo", 77'(fifo_cnt), 77'd0);
        tick;
        tick; out_ack_vld = 1'b0;
        #2 check("lit_sim_drain", 77'(outstd_cnt), 77'd0);

        // Backpressure with three requests offered
        tick; out_req_rdy = 1'b0; set_req(20);
        tick; set_req(21);
        tick; set_req(22);
        #2 check("lit_bp_in_rdy", 77'(in_req_rdy), 77'd0);
        check("lit_bp_fifo", 77'(fifo_cnt), 77'd2);
        check("lit_bp_head", 77'(out_req_addr), 77'(addr_of(20)));
        tick;
        #2 check("lit_bp_head_hold", 77'(out_req_addr), 77'(addr_of(20)));
        tick; out_req_rdy = 1'b1;
        tick;
        #2 check("lit_bp_second", 77'(out_req_addr), 77'(addr_of(21)));
        tick; in_req_vld = 1'b0;
        #2 check("lit_bp_third", 77'(out_req_addr), 77'(addr_of(22)));
        tick;
        #2 check("lit_bp_outstd", 77'(outstd_cnt), 77'd3);

        // Reset with fifo_cnt=2, outstd_cnt=3
        tick; out_req_rdy = 1'b0; set_req(30);
        tick; set_req(31);
        tick; in_req_vld = 1'b0;
        #2 check("lit_rst_pre_fifo", 77'(fifo_cnt), 77'd2);
        check("lit_rst_pre_outstd", 77'(outstd_cnt), 77'd3);
        tick; rst = 1'b1; out_req_rdy = 1'b1; set_req(32);
        tick; rst = 1'b0; in_req_vld = 1'b0;
        #2 check("lit_rst_fifo", 77'(fifo_cnt), 77'd0);
        check("lit_rst_outstd", 77'(outstd_cnt), 77'd0);
        check("lit_rst_vld", 77'(out_req_vld), 77'd0);
        check("lit_rst_in_rdy", 77'(in_req_rdy), 77'd1);
        tick;
        #2 check("lit_rst_no_stale", 77'(out_req_vld), 77'd0);

        // Spurious ack at outstd_cnt=0
        tick; out_ack_vld = 1'b1; out_ack_data = 32'h5A5A_5A5A; out_ack_src_id = 4'd3;
        #2 check("lit_spur_fwd", 77'(in_ack_vld), 77'd1);
        check("lit_spur_data", 77'(in_ack_data), 77'h5A5A_5A5A);
        tick; out_ack_vld = 1'b0;
        #2 check("lit_spur_err", 77'(err_underflow), 77'd1);
        check("lit_spur_outstd", 77'(outstd_cnt), 77'd0);
        tick;
        #2 check("lit_spur_sticky", 77'(err_underflow), 77'd1);
        tick; rst = 1'b1;
        tick; rst = 1'b0;
        #2 check("lit_spur_cleared", 77'(err_underflow), 77'd0);
        tick;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
